lsu: RTL and testbench
======================

# lsu

Load/store unit sitting directly downstream of the execute-stage ALU. It takes the effective address the ALU computes for load/store operations (base + offset), drives a single-outstanding request to data memory over a request/grant/response handshake, and aligns store data and byte strobes. It sign- or zero-extends load data and returns it to writeback. While an access is in flight it stalls the pipeline via `busy`.

## Interface
- `XLEN`, default 32: data/address width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  execute stage presents a load/store.
- `req_ready`  out  1  LSU can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as word.
- `req_unsigned`  in  1  zero-extend load (LBU/LHU); ignored for stores and words.
- `req_addr`  in  XLEN  effective address (ALU result).
- `req_wdata`  in  XLEN  store data (rs2).
- `req_rd`  in  5  load destination register.
- `mem_req`  out  1  memory request, held until granted.
- `mem_we`  out  1  request is a write.
- `mem_addr`  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- `mem_wstrb`  out  4  byte-lane write strobes; 0000 on reads.
- `mem_wdata`  out  XLEN  lane-replicated store data.
- `mem_gnt`  in  1  memory accepted the request this cycle.
- `mem_rvalid`  in  1  read data valid; earliest the cycle after `mem_gnt`.
- `mem_rdata`  in  XLEN  read word.
- `wb_valid`  out  1  one-cycle pulse with load result.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  XLEN  extended load data.
- `busy`  out  1  pipeline stall; `!req_ready`.
- `misalign`  out  1  one-cycle pulse on a misaligned access. Present only with `LSU_MISALIGN_TRAP_EN`.

## Operation
- FSM states: IDLE, REQ, WAIT.
  - IDLE: `req_valid` captures all `req_*` into holding registers. Next state is REQ, or IDLE with a misalign pulse when trapping.
  - REQ: `mem_req`=1 with stable `mem_*` until `mem_gnt`. On grant, a store goes to IDLE and a load goes to WAIT.
  - WAIT: on `mem_rvalid`, register the extracted data and `wb_valid`=1 next cycle, then go to IDLE.
- Store lanes:
  - byte: `wstrb` = 0001 << addr[1:0]; `wdata` = byte replicated ×4.
  - half: `wstrb` = addr[1] ? 1100 : 0011; `wdata` = half replicated ×2.
  - word: `wstrb` = 1111.
- Load extraction:
  - byte lane addr[1:0]; half lane addr[1].
  - Sign-extend from bit 7/15 unless `req_unsigned`.
  - Word passes through unchanged.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]≠00.
- `rd`=0 loads still access memory and pulse `wb_valid` with `wb_rd`=0.
- `mem_rvalid` outside WAIT is ignored.
- `mem_gnt` outside REQ is ignored.

## Timing
- Reset values: state IDLE; `req_ready`=1; `busy`=0; `mem_req`=0, `mem_we`=0, `mem_wstrb`=0000; `wb_valid`=0; `misalign`=0. `mem_addr`, `mem_wdata`, `wb_rd`, `wb_data` = 0.
- Accept at cycle 0; `mem_req` high from cycle 1.
- Store with immediate grant: back in IDLE at cycle 2.
- Load with grant at cycle 1 and rvalid at cycle 2: `wb_valid` at cycle 3, `req_ready` at cycle 3.
- `wb_valid` and `req_ready` may coincide; a new request may be accepted the same cycle.
- `rst` mid-access: next cycle is IDLE, `mem_req` drops, and no `wb_valid`. Any late `mem_rvalid` is discarded.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned request is accepted, issues no memory request, and produces no `wb_valid`.
  - `misalign` pulses the cycle after acceptance; state stays IDLE.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - No `misalign` port.
  - Offending low address bits are ignored: half uses addr[1] only, word uses neither.
  - Access proceeds normally.

## Structure
- `lsu_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the FSM state enum;
  - the misalignment-check function.
- Sub-module `lsu_align` (combinational):
  - store lane/strobe generation;
  - load lane select and extension.
- `lsu` holds the FSM and registers.

## Test plan
- SB addr 0x1003, wdata 0x000000A5, grant cycle 1 → `mem_addr` 0x1000, `wstrb` 1000, `wdata` 0xA5A5A5A5; `req_ready` high again at cycle 2.
- LH addr 0x2002, rdata 0x8001_1234, rvalid 2 cycles after grant → `wb_data` 0xFFFF8001. LHU same → 0x00008001.
- LW with `mem_gnt` held low 3 cycles → `mem_req` and all `mem_*` stable throughout, `busy`=1; `wb_valid` exactly one pulse.
- LW addr 0x3001 → with macro: `misalign` pulse, `mem_req` never asserted. Without macro: `mem_addr` 0x3000, normal load.
- `rst` in WAIT, then `mem_rvalid` next cycle → no `wb_valid`; IDLE; `req_ready`=1.
- Back-to-back LBU 0x10 then SW 0x14 → second accepted the cycle `wb_valid` pulses for the first; `wb_data` = zero-extended byte 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared size encodings, FSM states and misalignment check for lsu.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } lsu_state_t;

   // Reserved size 2'b11 behaves as a word.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return addr_lo[0];
         default: return |addr_lo;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module   : lsu_align
// Purpose  : Store lane/strobe generation and load lane select with extension.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      size,
   input  logic [1:0]      addr_lo,
   input  logic            is_unsigned,
   input  logic [XLEN-1:0] st_data,
   output logic [3:0]      st_strb,
   output logic [XLEN-1:0] st_wdata,
   input  logic [XLEN-1:0] ld_rdata,
   output logic [XLEN-1:0] ld_data
);

   logic [XLEN-1:0] w_shift;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;

   assign w_shift = ld_rdata >> {addr_lo, 3'b000};
   assign w_byte  = w_shift[7:0];
   assign w_half  = addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

   // Low address bits below the access size are simply not consulted.
   always_comb begin
      st_strb  = 4'b1111;
      st_wdata = st_data;
      ld_data  = ld_rdata;
      case (size)
         SZ_BYTE: begin
            st_strb  = 4'b0001 << addr_lo;
            st_wdata = {4{st_data[7:0]}};
            ld_data  = is_unsigned ? {{(XLEN-8){1'b0}}, w_byte}
                                   : {{(XLEN-8){w_byte[7]}}, w_byte};
         end
         SZ_HALF: begin
            st_strb  = addr_lo[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
            ld_data  = is_unsigned ? {{(XLEN-16){1'b0}}, w_half}
                                   : {{(XLEN-16){w_half[15]}}, w_half};
         end
         default: begin
            st_strb  = 4'b1111;
            st_wdata = st_data;
            ld_data  = ld_rdata;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
// Module   : lsu
// Purpose  : Single-outstanding load/store unit with request/grant/response
//            memory handshake. Optional macro: LSU_MISALIGN_TRAP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [4:0]      req_rd,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_wstrb,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            busy
`ifdef LSU_MISALIGN_TRAP_EN
   ,
   output logic            misalign
`endif
);

   lsu_state_t r_state, w_state_nxt;

   logic            w_accept;
   logic            w_trap;
   logic            w_ld_done;

   logic            r_we;
   logic [1:0]      r_size;
   logic            r_unsigned;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_wdata;
   logic [4:0]      r_rd;

   logic            r_wb_valid;
   logic [4:0]      r_wb_rd;
   logic [XLEN-1:0] r_wb_data;

   logic [3:0]      w_strb;
   logic [XLEN-1:0] w_st_wdata;
   logic [XLEN-1:0] w_ld_data;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_trap      = 1'b0;
      w_ld_done   = 1'b0;
      req_ready   = 1'b0;
      mem_req     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_accept = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
               w_trap = is_misaligned(req_size, req_addr[1:0]);
`endif
               if (!w_trap) w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            mem_req = 1'b1;
            if (mem_gnt) w_state_nxt = r_we ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               w_ld_done   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Holding registers keep every mem_* output stable while the grant is pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we       <= 1'b0;
         r_size     <= SZ_BYTE;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rd       <= '0;
      end else if (w_accept) begin
         r_we       <= req_we;
         r_size     <= req_size;
         r_unsigned <= req_unsigned;
         r_addr     <= req_addr;
         r_wdata    <= req_wdata;
         r_rd       <= req_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb_valid <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
      end else begin
         r_wb_valid <= w_ld_done;
         if (w_ld_done) begin
            r_wb_rd   <= r_rd;
            r_wb_data <= w_ld_data;
         end
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic r_misalign;

   always_ff @(posedge clk) begin
      if (rst) r_misalign <= 1'b0;
      else     r_misalign <= w_trap;
   end

   assign misalign = r_misalign;
`endif

   lsu_align #(
      .XLEN (XLEN)
   ) u_align (
      .size        (r_size),
      .addr_lo     (r_addr[1:0]),
      .is_unsigned (r_unsigned),
      .st_data     (r_wdata),
      .st_strb     (w_strb),
      .st_wdata    (w_st_wdata),
      .ld_rdata    (mem_rdata),
      .ld_data     (w_ld_data)
   );

   assign mem_we    = r_we;
   assign mem_addr  = {r_addr[XLEN-1:2], 2'b00};
   assign mem_wstrb = r_we ? w_strb : 4'b0000;
   assign mem_wdata = w_st_wdata;
   assign wb_valid  = r_wb_valid;
   assign wb_rd     = r_wb_rd;
   assign wb_data   = r_wb_data;
   assign busy      = !req_ready;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// Module   : tb_lsu
// Purpose  : Scoreboard bench for lsu with a byte-lane reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        wb_valid, busy;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   always #5 clk = ~clk;

   lsu #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy)
`ifdef LSU_MISALIGN_TRAP_EN
      , .misalign(misalign)
`endif
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } mreq_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   mreq_t exp_mem[$];
   wb_t   exp_wb[$];
   int    checks = 0;
   int    passed = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   // ---------------- reference model (byte-lane arithmetic) ----------------
   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   function automatic int lane_off(input logic [1:0] size, input logic [31:0] addr);
      int n;
      n = nbytes(size);
      return (int'(addr[1:0]) / n) * n;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                            input logic [31:0] addr, input logic [31:0] rdata);
      int n, off;
      longint v, span;
      n   = nbytes(size);
      off = lane_off(size, addr);
      if (n == 4) return rdata;
      span = longint'(1) << (8 * n);
      v    = (longint'(rdata) >> (8 * off)) % span;
      if (!uns && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   function automatic logic [3:0] ref_strb(input logic [1:0] size, input logic [31:0] addr);
      logic [3:0] s;
      int n, off;
      n   = nbytes(size);
      off = lane_off(size, addr);
      s   = 4'b0000;
      for (int i = 0; i < 4; i++) if (i >= off && i < off + n) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] d;
      int n;
      n = nbytes(size);
      for (int i = 0; i < 4; i++) d[8*i +: 8] = wdata[8*(i % n) +: 8];
      return d;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_req) begin
            chk("busy_during_req", busy, 1);
            if (exp_mem.size() == 0) chk("unexpected_mem_req", mem_req, 0);
            else begin
               chk("mem_we", mem_we, exp_mem[0].we);
               chk("mem_addr", mem_addr, exp_mem[0].addr);
               chk("mem_wstrb", mem_wstrb, exp_mem[0].strb);
               if (exp_mem[0].we) chk("mem_wdata", mem_wdata, exp_mem[0].wdata);
               if (mem_gnt) void'(exp_mem.pop_front());
            end
         end
         if (wb_valid) begin
            if (exp_wb.size() == 0) chk("unexpected_wb_valid", wb_valid, 0);
            else begin
               chk("wb_rd", wb_rd, exp_wb[0].rd);
               chk("wb_data", wb_data, exp_wb[0].data);
               void'(exp_wb.pop_front());
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input logic [31:0] rdata,
                        input int gdly, input int rdly);
      mreq_t m;
      wb_t   w;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_rd       = rd;
      chk("ready_at_issue", req_ready, 1);
`ifdef LSU_MISALIGN_TRAP_EN
      if ((int'(addr[1:0]) % nbytes(size)) != 0) begin
         tick();
         req_valid = 1'b0;
         chk("misalign_pulse", misalign, 1);
         chk("no_mem_req_on_trap", mem_req, 0);
         chk("ready_after_trap", req_ready, 1);
         tick();
         chk("misalign_single", misalign, 0);
         return;
      end
`endif
      m.we    = we;
      m.addr  = addr & 32'hFFFF_FFFC;
      m.strb  = we ? ref_strb(size, addr) : 4'b0000;
      m.wdata = ref_wdata(size, wdata);
      exp_mem.push_back(m);
      if (!we) begin
         w.rd   = rd;
         w.data = ref_load(size, uns, addr, rdata);
         exp_wb.push_back(w);
      end
      tick();
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_rd    = 5'($urandom);
      chk("mem_req_cycle1", mem_req, 1);
      repeat (gdly) begin
         mem_rvalid = 1'($urandom_range(0, 1));
         mem_rdata  = $urandom;
         tick();
      end
      mem_rvalid = 1'b0;
      mem_gnt    = 1'b1;
      tick();
      mem_gnt = 1'b0;
      if (we) begin
         chk("ready_after_store", req_ready, 1);
         chk("mem_req_drop", mem_req, 0);
      end else begin
         repeat (rdly) begin
            mem_gnt = 1'($urandom_range(0, 1));
            tick();
         end
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b1;
         mem_rdata  = rdata;
         tick();
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         chk("wb_pulse", wb_valid, 1);
         chk("ready_with_wb", req_ready, 1);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; req_rd = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (2) tick();
      rst = 1'b0;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_wstrb", mem_wstrb, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_data", wb_data, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("rst_misalign", misalign, 0);
`endif

      // SB, LH, LHU, stalled LW, misaligned LW
      do_op(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 5'd0, 32'h0, 0, 0);
      do_op(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 5'd3, 32'h8001_1234, 0, 1);
      do_op(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 5'd4, 32'h8001_1234, 0, 1);
      do_op(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 5'd5, 32'hCAFE_F00D, 3, 0);
      do_op(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 5'd6, 32'h1357_9BDF, 0, 0);
      tick();

      // reset while waiting for read data; the late rvalid must be discarded
      begin
         mreq_t m;
         req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
         req_addr = 32'h0000_0040; req_rd = 5'd7;
         m.we = 1'b0; m.addr = 32'h0000_0040; m.strb = 4'b0000; m.wdata = '0;
         exp_mem.push_back(m);
         tick();
         req_valid = 1'b0;
         mem_gnt   = 1'b1;
         tick();
         mem_gnt = 1'b0;
         rst     = 1'b1;
         tick();
         rst = 1'b0;
         chk("rst_wait_ready", req_ready, 1);
         chk("rst_wait_mem_req", mem_req, 0);
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hDEAD_BEEF;
         tick();
         mem_rvalid = 1'b0;
         chk("late_rvalid_no_wb", wb_valid, 0);
         chk("late_rvalid_ready", req_ready, 1);
      end

      // back-to-back LBU then SW, second accepted alongside the first wb pulse
      do_op(1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0, 5'd9, 32'h1234_56F0, 0, 0);
      chk("wb_with_accept", wb_valid, 1);
      do_op(1'b1, 2'b10, 1'b0, 32'h0000_0014, 32'h89AB_CDEF, 5'd0, 32'h0, 0, 0);

      // randomized traffic with ignored gnt/rvalid noise while idle
      for (int k = 0; k < 150; k++) begin
         int gap;
         do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               $urandom, $urandom, 5'($urandom), $urandom,
               $urandom_range(0, 3), $urandom_range(0, 2));
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            mem_gnt    = 1'($urandom_range(0, 1));
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            tick();
         end
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b0;
      end

      repeat (3) tick();
      chk("mem_queue_drained", exp_mem.size(), 0);
      chk("wb_queue_drained", exp_wb.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire
